fmul_seq: RTL and testbench
===========================

Name: fmul_seq

Overview:
Sequential IEEE-754-style floating-point multiplier. It is the companion to the team's combinational divider, uses the same operand format, and is the multiply half of the FP arithmetic unit. Operands enter through a valid/ready handshake, and the significand product uses an iterative radix-2 shift-add datapath. The rounded, flagged result leaves through a second valid/ready handshake.

Parameters:
exp, 8, exponent field width
frac, 23, stored fraction width
width, exp+frac+1, total word width (derived; do not override)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands a/b/round_mode valid
in_ready  out  1  block can accept operands
a  in  width  operand A {sign, exponent, fraction}
b  in  width  operand B
round_mode  in  1  1 = round-to-nearest-even, 0 = truncate
out_valid  out  1  r/flags valid
out_ready  in  1  consumer accepts result
r  out  width  product
flags  out  4  [3] invalid, [2] overflow, [1] underflow, [0] inexact

Behaviour:
- Reset (async on rst_n low): state=IDLE, in_ready=1, out_valid=0, r=0, flags=0; any in-flight operation is discarded.
- FSM states: IDLE -> MUL -> NORM -> DONE -> IDLE; IDLE -> DONE directly for special operands.
- IDLE: in_ready=1. On in_valid&in_ready, register a, b and round_mode.
  - Special operand pair: go to DONE.
  - Otherwise: go to MUL with counter=0 and accumulator=0.
- Operand classes:
  - exponent==0: zero. Subnormals flush to zero.
  - exponent all-ones with frac==0: inf.
  - exponent all-ones with frac!=0: NaN.
- Special results (sign = sa^sb unless NaN):
  - NaN input, or inf*0: r={0, all-ones, 1, zeros}, i.e. 0x7FC00000 at defaults; flags=4'b1000.
  - inf * nonzero: signed inf, flags=0.
  - zero * finite: signed zero, flags=0.
- MUL: 24x24 shift-add, one multiplier bit per cycle, LSB first, frac+1 cycles. Accumulator width is 2*frac+2.
- NORM (1 cycle): P = product.
  - If P[2frac+1]=1: m=P[2frac+1:frac+1], g=P[frac], s=|P[frac-1:0], e=ea+eb-bias+1.
  - Else: m=P[2frac:frac], g=P[frac-1], s=|P[frac-2:0], e=ea+eb-bias.
  - e is signed, exp+2 bits wide. bias=2^(exp-1)-1.
  - Round-to-nearest-even: increment when g&(s|m[0]). On carry-out, set m=1.0 and e=e+1. Truncate: no increment.
  - inexact = g|s.
  - If e >= 2^exp-1: overflow. Nearest gives signed inf; truncate gives signed max finite (exponent 2^exp-2, fraction all-ones). flags = overflow|inexact.
  - If e <= 0: flush to signed zero, flags = underflow|inexact.
  - Otherwise: r = {sign, e[exp-1:0], m[frac-1:0]}.
- DONE: out_valid=1, in_ready=0. r and flags hold stable until out_valid&out_ready, then go to IDLE. out_valid drops the next cycle.
- Latency from the accepting edge T:
  - Normal operands: out_valid at T+frac+3 (T+26 at defaults).
  - Special operands: out_valid at T+1.
- Throughput: one operation in flight. in_ready=0 in MUL, NORM and DONE. in_valid is ignored while busy.
- in_ready reasserts the cycle after the output handshake. No same-cycle accept and drain.

Test Plan:
- 0x3FC00000 * 0x40000000, round_mode=1, out_ready=1 -> r=0x40400000, flags=0, out_valid exactly 26 cycles after accept, held 1 cycle.
- 0x3F800001 * 0x3FC00000 (exact tie, lsb odd) -> nearest: r=0x3FC00002, flags=0001; truncate: r=0x3FC00001, flags=0001.
- 0x7F000000 * 0x7F000000 -> nearest: 0x7F800000, flags=0101; truncate: 0x7F7FFFFF, flags=0101. Then 0x00800000 * 0x3F000000 -> 0x00000000, flags=0011.
- 0x7F800000 * 0x00000000 -> 0x7FC00000, flags=1000, out_valid at T+1. 0xFF800000 * 0x40000000 -> 0xFF800000, flags=0.
- Hold out_ready=0 for 10 cycles in DONE -> r, flags and out_valid stable, in_ready=0, and pulses on in_valid are ignored. Release -> one handshake, then in_ready=1.
- Assert rst_n=0 mid-MUL (cycle 10) -> out_valid=0, r=0, flags=0, in_ready=1 immediately. A new operation after release completes correctly.

Source files
------------

// File: rtl/fmul_seq.sv
// Sequential floating-point multiplier: valid/ready operand intake, radix-2 shift-add
// significand product, single-cycle normalise/round, held result until drained.
module fmul_seq #(
    parameter  int EXP   = 8,
    parameter  int FRAC  = 23,
    localparam int WIDTH = EXP + FRAC + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             round_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic [3:0]       flags
);
    localparam int MW   = FRAC + 1;
    localparam int PW   = 2 * FRAC + 2;
    localparam int EW   = EXP + 2;
    localparam int CW   = $clog2(MW);
    localparam int BIAS = 2 ** (EXP - 1) - 1;
    localparam logic signed [EW-1:0] BIAS_S = EW'(BIAS);
    localparam logic signed [EW-1:0] E_OVF  = EW'(2 ** EXP - 1);
    localparam logic signed [EW-1:0] E_ZERO = '0;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_NORM, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [MW-1:0]         mplier_q, mplier_d;
    logic [PW-1:0]         mcand_q, mcand_d;
    logic [PW-1:0]         acc_q, acc_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  sign_q, sign_d;
    logic                  rm_q, rm_d;
    logic signed [EW-1:0]  esum_q, esum_d;
    logic [WIDTH-1:0]      r_q, r_d;
    logic [3:0]            flags_q, flags_d;

    // Operand classification on the live inputs, used only at the accepting edge
    logic [EXP-1:0]   ea, eb;
    logic [FRAC-1:0]  fa, fb;
    logic             a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, in_sign, is_special;
    logic [WIDTH-1:0] spec_r;
    logic [3:0]       spec_flags;

    always_comb begin
        ea = a[WIDTH-2:FRAC];
        eb = b[WIDTH-2:FRAC];
        fa = a[FRAC-1:0];
        fb = b[FRAC-1:0];
        in_sign = a[WIDTH-1] ^ b[WIDTH-1];
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_inf  = (&ea) && (fa == '0);
        b_inf  = (&eb) && (fb == '0);
        a_nan  = (&ea) && (fa != '0);
        b_nan  = (&eb) && (fb != '0);
        is_special = a_zero | b_zero | (&ea) | (&eb);
        spec_flags = 4'b0000;
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
            spec_r     = {1'b0, {EXP{1'b1}}, 1'b1, {(FRAC-1){1'b0}}};
            spec_flags = 4'b1000;
        end else if (a_inf || b_inf) begin
            spec_r = {in_sign, {EXP{1'b1}}, {FRAC{1'b0}}};
        end else begin
            spec_r = {in_sign, {(WIDTH-1){1'b0}}};
        end
    end

    // Normalise and round the finished product held in acc_q
    logic [MW-1:0]        nm, mf;
    logic [MW:0]          mr;
    logic                 ng, ns, inc;
    logic signed [EW-1:0] ne;
    logic [WIDTH-1:0]     norm_r;
    logic [3:0]           norm_flags;

    always_comb begin
        if (acc_q[PW-1]) begin
            nm = acc_q[PW-1:FRAC+1];
            ng = acc_q[FRAC];
            ns = |acc_q[FRAC-1:0];
            ne = esum_q + EW'(1);
        end else begin
            nm = acc_q[PW-2:FRAC];
            ng = acc_q[FRAC-1];
            ns = |acc_q[FRAC-2:0];
            ne = esum_q;
        end
        inc = rm_q & ng & (ns | nm[0]);
        mr  = {1'b0, nm} + {{MW{1'b0}}, inc};
        mf  = mr[MW-1:0];
        if (mr[MW]) begin
            mf = {1'b1, {FRAC{1'b0}}};
            ne = ne + EW'(1);
        end
        // Overflow and underflow always lose the true value, so inexact is forced
        if (ne >= E_OVF) begin
            norm_flags = 4'b0101;
            norm_r     = rm_q ? {sign_q, {EXP{1'b1}}, {FRAC{1'b0}}}
                              : {sign_q, {(EXP-1){1'b1}}, 1'b0, {FRAC{1'b1}}};
        end else if (ne <= E_ZERO) begin
            norm_flags = 4'b0011;
            norm_r     = {sign_q, {(WIDTH-1){1'b0}}};
        end else begin
            norm_flags = {3'b000, ng | ns};
            norm_r     = {sign_q, ne[EXP-1:0], mf[FRAC-1:0]};
        end
    end

    always_comb begin
        state_d  = state_q;
        mplier_d = mplier_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        rm_d     = rm_q;
        esum_d   = esum_q;
        r_d      = r_q;
        flags_d  = flags_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sign_d = in_sign;
                    rm_d   = round_mode;
                    if (is_special) begin
                        r_d     = spec_r;
                        flags_d = spec_flags;
                        state_d = S_DONE;
                    end else begin
                        mplier_d = {1'b1, fa};
                        mcand_d  = {{(PW-MW){1'b0}}, 1'b1, fb};
                        acc_d    = '0;
                        cnt_d    = '0;
                        esum_d   = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;
                        state_d  = S_MUL;
                    end
                end
            end
            S_MUL: begin
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mplier_d = mplier_q >> 1;
                mcand_d  = mcand_q << 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(MW - 1)) state_d = S_NORM;
            end
            S_NORM: begin
                r_d     = norm_r;
                flags_d = norm_flags;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mplier_q <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            rm_q     <= 1'b0;
            esum_q   <= '0;
            r_q      <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            mplier_q <= mplier_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            rm_q     <= rm_d;
            esum_q   <= esum_d;
            r_q      <= r_d;
            flags_q  <= flags_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign r         = r_q;
    assign flags     = flags_q;
endmodule

// File: tb/tb_fmul_seq.sv
// Directed and random checks of fmul_seq against an arithmetic reference model.
module tb_fmul_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        round_mode = 1'b1;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] r;
    logic [3:0]  flags;

    int errors = 0;
    int checks = 0;

    fmul_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .round_mode(round_mode), .out_valid(out_valid),
        .out_ready(out_ready), .r(r), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Exact integer product, then round by comparing the discarded remainder to one half
    function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y, input logic rm);
        logic [7:0]  ex, ey;
        logic [22:0] fx, fy;
        logic        s, xz, yz, xi, yi, xn, yn;
        longint      p, q, rem, half;
        int          e, sh;
        ex = x[30:23]; ey = y[30:23]; fx = x[22:0]; fy = y[22:0];
        s  = x[31] ^ y[31];
        xz = (ex == 0); yz = (ey == 0);
        xi = (ex == 8'hFF) && (fx == 0); yi = (ey == 8'hFF) && (fy == 0);
        xn = (ex == 8'hFF) && (fx != 0); yn = (ey == 8'hFF) && (fy != 0);
        if (xn || yn || (xi && yz) || (xz && yi)) return {32'h7FC00000, 4'b1000};
        if (xi || yi) return {s, 8'hFF, 23'h0, 4'b0000};
        if (xz || yz) return {s, 31'h0, 4'b0000};
        p = longint'({1'b1, fx}) * longint'({1'b1, fy});
        e = int'(ex) + int'(ey) - 127;
        sh = 23;
        if (p >= (longint'(1) << 47)) begin sh = 24; e = e + 1; end
        q    = p >> sh;
        rem  = p - (q << sh);
        half = longint'(1) << (sh - 1);
        if (rm && (rem > half || (rem == half && q[0]))) q = q + 1;
        if (q == (longint'(1) << 24)) begin q = longint'(1) << 23; e = e + 1; end
        if (e >= 255) return rm ? {s, 8'hFF, 23'h0, 4'b0101} : {s, 8'hFE, 23'h7FFFFF, 4'b0101};
        if (e <= 0) return {s, 31'h0, 4'b0011};
        return {s, e[7:0], q[22:0], 3'b000, (rem != 0)};
    endfunction

    function automatic bit is_special(input logic [31:0] x, input logic [31:0] y);
        return (x[30:23] == 0) || (y[30:23] == 0) || (x[30:23] == 8'hFF) || (y[30:23] == 8'hFF);
    endfunction

    // Latency counts the cycle following the accepting edge as 1
    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic trm, input logic [31:0] er, input logic [3:0] ef);
        int lat;
        int exp_lat;
        exp_lat = is_special(ta, tb_v) ? 1 : 26;
        @(negedge clk);
        check({tag, ".in_ready"}, 64'(in_ready), 64'(1));
        a = ta; b = tb_v; round_mode = trm; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        check({tag, ".r"}, 64'(r), 64'(er));
        check({tag, ".flags"}, 64'(flags), 64'(ef));
        $display("op %s a=%08h b=%08h rm=%0d -> r=%08h flags=%04b lat=%0d", tag, ta, tb_v, trm, r, flags, lat);
        @(posedge clk); #1;
        check({tag, ".drop"}, 64'(out_valid), 64'(0));
        check({tag, ".ready"}, 64'(in_ready), 64'(1));
    endtask

    initial begin
        logic [35:0] m;
        logic [31:0] ra, rb;
        logic        rrm;
        int          w;

        repeat (2) @(posedge clk);
        #1;
        check("rst.in_ready", 64'(in_ready), 64'(1));
        check("rst.out_valid", 64'(out_valid), 64'(0));
        check("rst.r", 64'(r), 64'(0));
        check("rst.flags", 64'(flags), 64'(0));
        @(negedge clk) rst_n = 1'b1;

        run_op("basic", 32'h3FC00000, 32'h40000000, 1'b1, 32'h40400000, 4'b0000);
        run_op("tie_rne", 32'h3F800001, 32'h3FC00000, 1'b1, 32'h3FC00002, 4'b0001);
        run_op("tie_trunc", 32'h3F800001, 32'h3FC00000, 1'b0, 32'h3FC00001, 4'b0001);
        run_op("ovf_rne", 32'h7F000000, 32'h7F000000, 1'b1, 32'h7F800000, 4'b0101);
        run_op("ovf_trunc", 32'h7F000000, 32'h7F000000, 1'b0, 32'h7F7FFFFF, 4'b0101);
        run_op("unf", 32'h00800000, 32'h3F000000, 1'b1, 32'h00000000, 4'b0011);
        run_op("inf_x_0", 32'h7F800000, 32'h00000000, 1'b1, 32'h7FC00000, 4'b1000);
        run_op("ninf_x_2", 32'hFF800000, 32'h40000000, 1'b1, 32'hFF800000, 4'b0000);
        run_op("nan_in", 32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000);
        run_op("neg_zero", 32'h80000000, 32'h40A00000, 1'b1, 32'h80000000, 4'b0000);

        // Backpressure: result held while in_valid pulses are ignored
        @(negedge clk);
        a = 32'h3FC00000; b = 32'h40000000; round_mode = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 100) begin @(posedge clk); #1; w++; end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = $urandom; b = $urandom;
            @(posedge clk); #1;
            check("hold.out_valid", 64'(out_valid), 64'(1));
            check("hold.r", 64'(r), 64'h40400000);
            check("hold.flags", 64'(flags), 64'(0));
            check("hold.in_ready", 64'(in_ready), 64'(0));
            $display("hold cycle %0d out_valid=%0d r=%08h in_ready=%0d", i, out_valid, r, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("release.out_valid", 64'(out_valid), 64'(0));
        check("release.in_ready", 64'(in_ready), 64'(1));
        $display("release out_valid=%0d in_ready=%0d", out_valid, in_ready);

        // Asynchronous reset in the middle of the multiply
        @(negedge clk);
        a = 32'h40490FDB; b = 32'h402DF854; round_mode = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst.out_valid", 64'(out_valid), 64'(0));
        check("midrst.r", 64'(r), 64'(0));
        check("midrst.flags", 64'(flags), 64'(0));
        check("midrst.in_ready", 64'(in_ready), 64'(1));
        $display("mid-mul reset out_valid=%0d r=%08h flags=%04b in_ready=%0d", out_valid, r, flags, in_ready);
        @(negedge clk) rst_n = 1'b1;
        m = model(32'h40490FDB, 32'h402DF854, 1'b1);
        run_op("post_rst", 32'h40490FDB, 32'h402DF854, 1'b1, m[35:4], m[3:0]);

        for (int i = 0; i < 40; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            rrm = 1'($urandom_range(0, 1));
            if (i % 3 != 0) begin
                ra[30:23] = 8'($urandom_range(100, 154));
                rb[30:23] = 8'($urandom_range(100, 154));
            end
            m = model(ra, rb, rrm);
            run_op($sformatf("rand%0d", i), ra, rb, rrm, m[35:4], m[3:0]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
